// File: rtl/pong_game_ctrl.sv
// Game sequencer for the pong display: walks through new game, play, new ball
// and game over, keeps the BCD score and the remaining-ball count, and tells
// the graph subsystem when to freeze the ball and paddle.
module pong_game_ctrl #(
    parameter int NUM_BALLS   = 3,
    parameter int WAIT_FRAMES = 120
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] btn,
    input  logic       frame_tick,
    input  logic       hit,
    input  logic       miss,
    output logic       graph_still,
    output logic [1:0] ball_cnt,
    output logic [3:0] score_d1,
    output logic [3:0] score_d0,
    output logic       show_logo,
    output logic       show_over,
    output logic       play_on
);

    typedef enum logic [1:0] {
        NEWGAME = 2'd0,
        PLAY    = 2'd1,
        NEWBALL = 2'd2,
        OVER    = 2'd3
    } state_t;

    localparam logic [1:0] BALLS_FULL  = 2'(NUM_BALLS);
    localparam logic [1:0] BALLS_FIRST = 2'(NUM_BALLS - 1);
    localparam logic [7:0] TIMER_LOAD  = 8'(WAIT_FRAMES - 1);

    state_t     state;
    logic [7:0] timer;
    logic [1:0] btn_q;
    logic       press;
    logic       timer_done;

    // A press is a rising edge on either button; btn_q resetting to all-ones
    // keeps a button held through reset from looking like a fresh press.
    assign press      = |(btn & ~btn_q);
    assign timer_done = (timer == 8'd0) && frame_tick;

    // Status outputs decode straight off the state register so they change on
    // the same edge as the state itself.
    assign graph_still = (state != PLAY);
    assign show_logo   = (state == NEWGAME);
    assign show_over   = (state == OVER);
    assign play_on     = (state == PLAY);

    // Game sequencer: state, score, ball count, frame timer and button history.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= NEWGAME;
            ball_cnt <= BALLS_FULL;
            score_d1 <= 4'd0;
            score_d0 <= 4'd0;
            timer    <= 8'd0;
            btn_q    <= 2'b11;
        end else begin
            btn_q <= btn;

            if (frame_tick && (timer != 8'd0)) begin
                timer <= timer - 8'd1;
            end

            case (state)
                NEWGAME: begin
                    if (press) begin
                        state    <= PLAY;
                        score_d1 <= 4'd0;
                        score_d0 <= 4'd0;
                        ball_cnt <= BALLS_FIRST;
                    end
                end

                PLAY: begin
                    if (hit) begin
                        if (score_d0 != 4'd9) begin
                            score_d0 <= score_d0 + 4'd1;
                        end else if (score_d1 != 4'd9) begin
                            score_d0 <= 4'd0;
                            score_d1 <= score_d1 + 4'd1;
                        end
                    end
                    if (miss) begin
                        timer <= TIMER_LOAD;
                        if (ball_cnt == 2'd0) begin
                            state <= OVER;
                        end else begin
                            ball_cnt <= ball_cnt - 2'd1;
                            state    <= NEWBALL;
                        end
                    end
                end

                NEWBALL: begin
                    if (press && (timer == 8'd0)) begin
                        state <= PLAY;
                    end
                end

                OVER: begin
                    if (timer_done) begin
                        state    <= NEWGAME;
                        ball_cnt <= BALLS_FULL;
                    end
                end

                default: begin
                    state <= NEWGAME;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Scoreboard bench for pong_game_ctrl: a behavioural game model predicts the
// outputs for each driven cycle, queues them, and they are compared after the edge.
module tb_pong_game_ctrl;

    localparam int NB = 3;
    localparam int WF = 120;

    localparam int M_NG   = 0;
    localparam int M_PLAY = 1;
    localparam int M_NB   = 2;
    localparam int M_OVER = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] btn;
    logic       frame_tick;
    logic       hit;
    logic       miss;
    logic       graph_still;
    logic [1:0] ball_cnt;
    logic [3:0] score_d1;
    logic [3:0] score_d0;
    logic       show_logo;
    logic       show_over;
    logic       play_on;

    typedef struct {
        int gs;
        int bc;
        int d1;
        int d0;
        int logo;
        int over;
        int play;
    } exp_t;

    exp_t sb_q[$];

    int errors = 0;
    int checks = 0;

    int         m_state;
    int         m_score;
    int         m_balls;
    int         m_timer;
    logic [1:0] m_btnq;

    // Free-running system clock.
    always #5 clk = ~clk;

    pong_game_ctrl #(
        .NUM_BALLS  (NB),
        .WAIT_FRAMES(WF)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .btn        (btn),
        .frame_tick (frame_tick),
        .hit        (hit),
        .miss       (miss),
        .graph_still(graph_still),
        .ball_cnt   (ball_cnt),
        .score_d1   (score_d1),
        .score_d0   (score_d0),
        .show_logo  (show_logo),
        .show_over  (show_over),
        .play_on    (play_on)
    );

    task automatic checkOutput(input string tag, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    // Behavioural model of one clock edge; score is kept as a plain integer.
    task automatic modelStep(input logic [1:0] b, input logic f, input logic h,
                             input logic m, input logic r);
        logic pr;
        logic td;
        int   t_old;
        if (r) begin
            m_state = M_NG;
            m_score = 0;
            m_balls = NB;
            m_timer = 0;
            m_btnq  = 2'b11;
        end else begin
            pr    = |(b & ~m_btnq);
            td    = (m_timer == 0) && f;
            t_old = m_timer;
            m_btnq = b;
            if (f && m_timer > 0) m_timer = m_timer - 1;
            case (m_state)
                M_NG: begin
                    if (pr) begin
                        m_state = M_PLAY;
                        m_score = 0;
                        m_balls = NB - 1;
                    end
                end
                M_PLAY: begin
                    if (h && m_score < 99) m_score = m_score + 1;
                    if (m) begin
                        m_timer = WF - 1;
                        if (m_balls == 0) begin
                            m_state = M_OVER;
                        end else begin
                            m_balls = m_balls - 1;
                            m_state = M_NB;
                        end
                    end
                end
                M_NB: begin
                    if (pr && t_old == 0) m_state = M_PLAY;
                end
                default: begin
                    if (td) begin
                        m_state = M_NG;
                        m_balls = NB;
                    end
                end
            endcase
        end
    endtask

    // Drive one cycle, queue the predicted outputs, then compare after the edge.
    task automatic applyStimulus(input logic [1:0] b, input logic f, input logic h,
                                 input logic m, input logic r);
        exp_t e;
        exp_t got;
        @(negedge clk);
        btn        = b;
        frame_tick = f;
        hit        = h;
        miss       = m;
        reset      = r;
        modelStep(b, f, h, m, r);
        e.gs   = (m_state != M_PLAY) ? 1 : 0;
        e.bc   = m_balls;
        e.d1   = m_score / 10;
        e.d0   = m_score % 10;
        e.logo = (m_state == M_NG) ? 1 : 0;
        e.over = (m_state == M_OVER) ? 1 : 0;
        e.play = (m_state == M_PLAY) ? 1 : 0;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            checkOutput("scoreboard_empty", 0, 1);
        end else begin
            got = sb_q.pop_front();
            checkOutput("graph_still", int'(graph_still), got.gs);
            checkOutput("ball_cnt",    int'(ball_cnt),    got.bc);
            checkOutput("score_d1",    int'(score_d1),    got.d1);
            checkOutput("score_d0",    int'(score_d0),    got.d0);
            checkOutput("show_logo",   int'(show_logo),   got.logo);
            checkOutput("show_over",   int'(show_over),   got.over);
            checkOutput("play_on",     int'(play_on),     got.play);
        end
    endtask

    task automatic idle(input int n, input logic [1:0] b, input logic f);
        for (int i = 0; i < n; i++) applyStimulus(b, f, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic pressBtn(input logic [1:0] b);
        applyStimulus(b, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic hits(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
            applyStimulus(2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic missBall();
        applyStimulus(2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    // Time limit so the bench always reaches its summary.
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        btn        = 2'b01;
        frame_tick = 1'b0;
        hit        = 1'b0;
        miss       = 1'b0;
        reset      = 1'b1;

        // Reset with btn[0] held, hold it after reset, then release and press.
        applyStimulus(2'b01, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(2'b01, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(3, 2'b01, 1'b1);
        idle(2, 2'b00, 1'b0);
        pressBtn(2'b01);

        // Scoring: 12 hits, then on to 98 and saturate at 99.
        hits(12);
        hits(86);
        hits(3);

        // First miss: new ball with early presses and a press at timer==1 ignored.
        missBall();
        idle(50, 2'b00, 1'b1);
        pressBtn(2'b01);
        idle(68, 2'b00, 1'b1);
        pressBtn(2'b10);
        idle(1, 2'b00, 1'b1);
        idle(1, 2'b00, 1'b1);
        pressBtn(2'b10);

        // Second miss, then last ball lost.
        missBall();
        idle(119, 2'b00, 1'b1);
        pressBtn(2'b01);
        missBall();

        // Game over: a press mid-wait is ignored, then back to new game.
        idle(60, 2'b00, 1'b1);
        pressBtn(2'b11);
        idle(60, 2'b00, 1'b1);
        idle(3, 2'b00, 1'b0);

        // New game clears the score; same-cycle hit and miss at score 07.
        pressBtn(2'b01);
        hits(7);
        missBall();
        idle(119, 2'b00, 1'b1);
        pressBtn(2'b01);
        applyStimulus(2'b00, 1'b0, 1'b1, 1'b1, 1'b0);

        // Reach game over, then reset mid-count with a button held.
        idle(119, 2'b00, 1'b1);
        pressBtn(2'b01);
        missBall();
        idle(60, 2'b00, 1'b1);
        applyStimulus(2'b01, 1'b1, 1'b0, 1'b0, 1'b1);
        idle(130, 2'b01, 1'b1);
        idle(2, 2'b00, 1'b0);
        pressBtn(2'b10);
        hits(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
